// File: rtl/mux6_rr_scheduler.sv
// mux6_rr_scheduler: six-requester round-robin scheduler driving a shared
// 6:1 payload mux with a registered valid/ready output stage.
//
// Handshake: out_valid rises with a captured payload and then holds sel, gnt
// and out_data stable until a cycle where out_valid && out_ready are both
// high at the rising edge; that edge completes the transfer. out_valid never
// drops without a completion, except through reset.
//
// Optional feature: define MUX6_SCHED_LOCK_EN to add the lock input. A
// completing requester whose lock and req bits are both set is granted again
// and the round-robin pointer stays where it is.
module mux6_rr_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic [WIDTH-1:0] data4,
  input  logic [WIDTH-1:0] data5,
  input  logic             out_ready,
`ifdef MUX6_SCHED_LOCK_EN
  input  logic [5:0]       lock,
`endif
  output logic [2:0]       sel,
  output logic [5:0]       gnt,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             dbg_state_o,
  output logic [2:0]       dbg_ptr_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [2:0] SEL_NONE = 3'b111;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       sel_q, sel_d;
  logic [5:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [WIDTH-1:0] data_arr [6];
  logic [2:0]       nxt_ptr;
  logic [2:0]       pick_idle;
  logic [2:0]       pick_done;
  logic             relock;
  logic             load_en;
  logic [2:0]       load_idx;

  // First set request bit at or after start, wrapping 5 -> 0; 3'b111 if none.
  // Walking the offsets from far to near lets the nearest hit win.
  function automatic logic [2:0] rr_find(input logic [5:0] r, input logic [2:0] start);
    logic [3:0] pos;
    rr_find = SEL_NONE;
    for (int k = 5; k >= 0; k--) begin
      pos = {1'b0, start} + k[3:0];
      if (pos >= 4'd6) pos = pos - 4'd6;
      if (r[pos[2:0]]) rr_find = pos[2:0];
    end
  endfunction

  assign data_arr[0] = data0;
  assign data_arr[1] = data1;
  assign data_arr[2] = data2;
  assign data_arr[3] = data3;
  assign data_arr[4] = data4;
  assign data_arr[5] = data5;

  // Pointer after a completion, and the candidate winners for both states.
  assign nxt_ptr   = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
  assign pick_idle = rr_find(req, ptr_q);
  assign pick_done = rr_find(req, nxt_ptr);

`ifdef MUX6_SCHED_LOCK_EN
  assign relock = lock[sel_q] & req[sel_q];
`else
  assign relock = 1'b0;
`endif

  // Next-state logic: grant from IDLE, hold under backpressure, and on
  // completion either re-grant (lock), grant the next requester, or go idle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    data_d   = data_q;
    load_en  = 1'b0;
    load_idx = pick_idle;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          load_en  = 1'b1;
          load_idx = pick_idle;
        end
      end
      ST_GRANT: begin
        if (out_ready) begin
          if (relock) begin
            load_en  = 1'b1;
            load_idx = sel_q;
          end else begin
            ptr_d = nxt_ptr;
            if (|req) begin
              load_en  = 1'b1;
              load_idx = pick_done;
            end else begin
              state_d = ST_IDLE;
              sel_d   = SEL_NONE;
              gnt_d   = 6'b0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_en) begin
      state_d = ST_GRANT;
      sel_d   = load_idx;
      gnt_d   = 6'b000001 << load_idx;
      data_d  = data_arr[load_idx];
    end
  end

  // State, pointer and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= SEL_NONE;
      gnt_q   <= 6'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
    end
  end

  assign sel         = sel_q;
  assign gnt         = gnt_q;
  assign out_data    = data_q;
  assign out_valid   = (state_q == ST_GRANT);
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: doc/mux6_rr_scheduler.md
MUX6_RR_SCHEDULER -- requirements
Module: mux6_rr_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of each requester and of the output.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port req, input, 6, per-requester level request; bit i belongs to requester i.
REQ-005 SHALL have ports data0..data5, input, WIDTH each, requester payloads.
REQ-006 SHALL have port out_ready, input, 1, consumer accepts out_data when high with out_valid.
REQ-007 SHALL have port sel, output, 3, registered select of the shared 6:1 mux; 3'b111 = none.
REQ-008 SHALL have port gnt, output, 6, registered one-hot grant; all-zero when nothing is granted.
REQ-009 SHALL have port out_data, output, WIDTH, registered payload of the granted requester.
REQ-010 SHALL have port out_valid, output, 1, out_data holds an unaccepted transfer.

Function
REQ-011 SHALL implement two states: IDLE (out_valid=0) and GRANT (out_valid=1).
REQ-012 SHALL hold a 3-bit round-robin pointer ptr (0..5); search order ptr, ptr+1, ... 5, 0, ... ptr-1.
REQ-013 IDLE: with any req bit set, SHALL select the first set bit in search order, load sel/gnt with that index, capture data<index> into out_data, set out_valid, and go to GRANT on the same edge.
REQ-014 GRANT: with out_ready=0, SHALL hold sel, gnt, out_data and out_valid unchanged, whatever req or data inputs do.
REQ-015 GRANT with out_ready=1: transfer completes; ptr SHALL become (granted index + 1), with 5 wrapping to 0.
REQ-016 On completion with any req set, SHALL grant the next requester on the same edge, searching from the updated ptr; this gives back-to-back transfers of one per cycle.
REQ-017 On completion with req all zero, SHALL return to IDLE with sel=3'b111, gnt=0, out_valid=0; out_data SHALL keep its last value.
REQ-018 req is level-sensitive; a requester still asserting req after acceptance SHALL be eligible again at lowest priority.
REQ-019 A req bit dropping while that requester is granted SHALL NOT cancel the transfer.
REQ-020 sel and gnt SHALL always be consistent: gnt = 1<<sel when sel<6, otherwise gnt = 0.
REQ-021 sel values 6 and 7 SHALL only ever appear as 3'b111.
REQ-022 Latency from req to out_valid SHALL be exactly one clock edge when the scheduler is idle.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, ptr=0, sel=3'b111, gnt=0, out_data=0 and out_valid=0.
REQ-024 Reset mid-transfer SHALL discard the pending transfer without asserting completion.
REQ-025 After rst_n rises, the first grant SHALL follow REQ-013 with ptr=0.

Configuration
REQ-026 Macro MUX6_SCHED_LOCK_EN, when defined, SHALL add a port lock, input, 6.
REQ-027 With the macro defined, on completion with lock[granted]=1 and req[granted]=1, SHALL re-grant the same requester and leave ptr unchanged.
REQ-028 Without the macro, the lock port SHALL be absent and behaviour SHALL be pure round-robin per REQ-015/016.

Verification
REQ-029 Reset: rst_n=0 with req=6'h3F -> sel=3'b111, gnt=0, out_valid=0, out_data=0 without waiting for a clock edge.
REQ-030 Single request: data0..5=a,b,c,d,e,f, req=6'b000100, out_ready=1 -> after one edge sel=2, gnt=6'b000100, out_data=4'hc, out_valid=1.
REQ-031 Full load: req=6'h3F, out_ready=1 held -> out_data sequence a,b,c,d,e,f,a on consecutive cycles, sel 0..5 then 0.
REQ-032 Backpressure: req=6'b010000 with out_ready=0 for 3 cycles, data4 changed to 0 -> out_data stays 4'he and out_valid stays 1.
REQ-033 Backpressure release: out_ready=1 with req cleared -> one transfer, ptr=5, IDLE next cycle with sel=3'b111.
REQ-034 Wrap plus lock: after grant 4, req=6'b100001 -> grants 5 then 0; with MUX6_SCHED_LOCK_EN, lock=6'b000010, req=6'h3F -> sel stays 1 across 4 transfers.
